usb_utm_ctrl: RTL and testbench
===============================

// Module: usb_utm_ctrl
// PURPOSE
//  Link-state controller for the FS UTM. Watches line_state and bus activity, and detects
//  bus reset, suspend and host resume. Sequences the UTM suspend_m/op_mode controls.
//  Sits between the UTM and the SIE/protocol layer; optionally drives device remote wakeup.
// PARAMETERS
//  RST_CYC      120     consecutive SE0 samples that declare bus reset (2.5us @48MHz)
//  SUSP_CYC     144000  consecutive idle-J samples that declare suspend (3ms)
//  RES_CYC      120     consecutive K samples in SUSPEND that declare host resume
//  RWK_WAIT_CYC 240000  min cycles in SUSPEND before remote wakeup is allowed (5ms)
//  RWK_DRV_CYC  96000   cycles remote-wakeup K is driven (2ms)
// PORTS
//  clk           in   1  clock
//  rst_n         in   1  reset, synchronous, active-low
//  dev_en        in   1  device attached/enabled; 0 = non-driving, FSM held in ACTIVE
//  line_state    in   2  utm_line_state_t from UTM (00 SE0, 01 J, 10 K, 11 SE1)
//  rx_active     in   1  UTM receive active
//  tx_busy       in   1  SIE transmit in progress
//  rwake_req     in   1  remote wakeup request (level, sampled in SUSPEND)
//  suspend_m     out  1  to UTM; 0 = suspend
//  op_mode       out  2  utm_op_mode_t to UTM
//  usb_reset     out  1  level, high while in BUS_RESET
//  suspended     out  1  level, high while in SUSPEND
//  resume_pulse  out  1  1-cycle pulse on RESUME->ACTIVE or RWAKE completion
//  wk_tx_valid   out  1  remote-wakeup tx_valid, muxed onto UTM tx_valid by SIE
//  wk_data       out  8  remote-wakeup data_in, always 8'h00
// BEHAVIOUR
//  - All outputs are registered. Reset values: state=ACTIVE, suspend_m=1, op_mode=2'b01
//    (non-driving), usb_reset=0, suspended=0, resume_pulse=0, wk_tx_valid=0, wk_data=0.
//    Both counters are cleared.
//  - cond counter: counts consecutive cycles in which the monitored condition holds.
//    It clears whenever the condition is false or changes class. It saturates and never wraps.
//    Width is $clog2 of the largest *_CYC + 1.
//  - state timer: counts cycles since the last state change. It saturates.
//  - Condition met on the N-th consecutive sample; state/output change on the next edge.
//  - dev_en=0: state=ACTIVE, counters cleared, op_mode=01, suspend_m=1. dev_en=1: op_mode=00
//    except in RWAKE.
//  - ACTIVE:
//    - SE0 for RST_CYC -> BUS_RESET.
//    - J with rx_active=0 and tx_busy=0 for SUSP_CYC -> SUSPEND.
//  - BUS_RESET: usb_reset=1. Any line_state != SE0 -> ACTIVE. usb_reset falls the same edge.
//  - SUSPEND: suspended=1, suspend_m=0.
//    - SE0 for RST_CYC -> BUS_RESET (suspend_m=1).
//    - K for RES_CYC -> RESUME.
//    - SE0/K detection has priority over rwake_req.
//  - RESUME: suspend_m=1, suspended=0.
//    - J -> ACTIVE with resume_pulse.
//    - SE0 for RST_CYC -> BUS_RESET.
//  - SE1 is never a counted condition; it clears the cond counter.
//  - rst_n low mid-operation (any state incl. RWAKE): reset values on the next edge.
// CONFIGURATION
//  USB_UTM_CTRL_RWAKE_EN defined:
//    - Entry: SUSPEND with state timer >= RWK_WAIT_CYC, rwake_req=1 and line_state==J -> RWAKE.
//    - In RWAKE: suspend_m=1, op_mode=2'b10, wk_tx_valid=1, wk_data=8'h00.
//    - Exit: after RWK_DRV_CYC cycles, wk_tx_valid=0 and op_mode=00 -> RESUME.
//    - Host K continuation then follows the RESUME rules.
//  Undefined: no RWAKE state. rwake_req is ignored; wk_tx_valid and wk_data are tied to 0.
// STRUCTURE
//  usb_utm_pkg: existing utm_line_state_t/utm_op_mode_t. Add utm_ctrl_state_t
//    (ACTIVE, BUS_RESET, SUSPEND, RESUME, RWAKE) and localparams for the LS_* and OPM_* encodings.
//  Sub-module usb_utm_cond_timer: saturating counter with clear/enable and a
//    >= threshold compare. Instantiated twice (cond counter, state timer).
// TESTING  (RST_CYC=4 SUSP_CYC=16 RES_CYC=4 RWK_WAIT_CYC=20 RWK_DRV_CYC=8)
//  1. rst_n=0 then 1, dev_en=0 -> op_mode=01, suspend_m=1. dev_en=1 -> op_mode=00 next edge.
//  2. SE0 x3 then J -> no usb_reset. SE0 x4 -> usb_reset=1 on the next edge.
//     J -> usb_reset=0 on the following edge.
//  3. J idle x16 -> suspended=1, suspend_m=0. J x15 with a rx_active pulse mid-way -> no suspend.
//  4. In SUSPEND: K x4 -> RESUME, suspend_m=1. Then SE0 x2, J -> resume_pulse=1 for 1 cycle,
//     state ACTIVE.
//  5. RWAKE_EN: rwake_req at 10 cycles into SUSPEND -> ignored. Held to 20 cycles ->
//     op_mode=10, wk_tx_valid=1 for 8 cycles, then RESUME. Same with SE0 present -> BUS_RESET wins.
//  6. rst_n=0 during RWAKE -> wk_tx_valid=0, op_mode=01, state ACTIVE next edge.

Source files
------------

// File: rtl/usb_utm_pkg.sv
// rtl/usb_utm_pkg.sv - UTM line-state/op-mode encodings and link-state controller types.
package usb_utm_pkg;

  typedef logic [1:0] utm_line_state_t;
  typedef logic [1:0] utm_op_mode_t;

  localparam utm_line_state_t LS_SE0 = 2'b00;
  localparam utm_line_state_t LS_J   = 2'b01;
  localparam utm_line_state_t LS_K   = 2'b10;
  localparam utm_line_state_t LS_SE1 = 2'b11;

  localparam utm_op_mode_t OPM_NORMAL  = 2'b00;
  localparam utm_op_mode_t OPM_NODRIVE = 2'b01;
  localparam utm_op_mode_t OPM_NOSTUFF = 2'b10;

  typedef enum logic [2:0] {
    ACTIVE    = 3'd0,
    BUS_RESET = 3'd1,
    SUSPEND   = 3'd2,
    RESUME    = 3'd3,
    RWAKE     = 3'd4
  } utm_ctrl_state_t;

  // Class of line condition being run-length counted in the current state.
  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_SE0  = 2'd1,
    COND_IDLE = 2'd2,
    COND_K    = 2'd3
  } utm_cond_t;

  function automatic int max_cyc(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/usb_utm_cond_timer.sv
// rtl/usb_utm_cond_timer.sv - saturating cycle counter with clear/enable and >= threshold compare.
module usb_utm_cond_timer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] thresh,
  output logic         hit
);

  logic [W-1:0] cnt;

  // clr together with en restarts the run at one so the current sample still counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= {{(W-1){1'b0}}, en};
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt >= thresh);

endmodule

// File: rtl/usb_utm_ctrl.sv
// rtl/usb_utm_ctrl.sv - FS UTM link-state controller: bus reset, suspend, resume detection.
// Remote wakeup is built only when USB_UTM_CTRL_RWAKE_EN is defined.
module usb_utm_ctrl
  import usb_utm_pkg::*;
#(
  parameter int RST_CYC      = 120,
  parameter int SUSP_CYC     = 144000,
  parameter int RES_CYC      = 120,
  parameter int RWK_WAIT_CYC = 240000,
  parameter int RWK_DRV_CYC  = 96000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dev_en,
  input  logic [1:0] line_state,
  input  logic       rx_active,
  input  logic       tx_busy,
  input  logic       rwake_req,
  output logic       suspend_m,
  output logic [1:0] op_mode,
  output logic       usb_reset,
  output logic       suspended,
  output logic       resume_pulse,
  output logic       wk_tx_valid,
  output logic [7:0] wk_data
);

  localparam int MAX_CYC = max_cyc(RST_CYC, SUSP_CYC, RES_CYC, RWK_WAIT_CYC, RWK_DRV_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RST_TH  = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] SUSP_TH = CNT_W'(SUSP_CYC);
  localparam logic [CNT_W-1:0] RES_TH  = CNT_W'(RES_CYC);
  localparam logic [CNT_W-1:0] WAIT_TH = CNT_W'(RWK_WAIT_CYC);
  localparam logic [CNT_W-1:0] DRV_TH  = CNT_W'(RWK_DRV_CYC - 1);

  utm_ctrl_state_t  state, next_state;
  utm_cond_t        cond_cls, cls_q;
  logic             state_chg;
  logic             cond_clr, cond_en, cond_hit;
  logic             tmr_clr, tmr_en, tmr_hit;
  logic [CNT_W-1:0] cond_thresh, tmr_thresh;
  logic             se0_hit, idle_hit, k_hit;

  logic       nx_suspend_m, nx_usb_reset, nx_suspended, nx_resume_pulse, nx_wk_tx_valid;
  logic [1:0] nx_op_mode;

  always_comb begin
    cond_cls = COND_NONE;
    if (line_state == LS_SE0 && (state inside {ACTIVE, SUSPEND, RESUME})) begin
      cond_cls = COND_SE0;
    end else if (state == ACTIVE && line_state == LS_J && !rx_active && !tx_busy) begin
      cond_cls = COND_IDLE;
    end else if (state == SUSPEND && line_state == LS_K) begin
      cond_cls = COND_K;
    end
  end

  always_comb begin
    cond_thresh = SUSP_TH;
    case (cls_q)
      COND_SE0: cond_thresh = RST_TH;
      COND_K:   cond_thresh = RES_TH;
      default:  cond_thresh = SUSP_TH;
    endcase
  end

  assign tmr_thresh = (state == RWAKE) ? DRV_TH : WAIT_TH;

  // A registered run length that reached its threshold acts on the following edge.
  assign se0_hit  = cond_hit && (cls_q == COND_SE0);
  assign idle_hit = cond_hit && (cls_q == COND_IDLE);
  assign k_hit    = cond_hit && (cls_q == COND_K);

  assign state_chg = (next_state != state);
  assign cond_clr  = state_chg || !dev_en || (cond_cls != cls_q);
  assign cond_en   = dev_en && !state_chg && (cond_cls != COND_NONE);
  assign tmr_clr   = state_chg || !dev_en;
  assign tmr_en    = dev_en && !state_chg;

  usb_utm_cond_timer #(.W(CNT_W)) u_cond_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cond_clr),
    .en     (cond_en),
    .thresh (cond_thresh),
    .hit    (cond_hit)
  );

  usb_utm_cond_timer #(.W(CNT_W)) u_state_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .thresh (tmr_thresh),
    .hit    (tmr_hit)
  );

`ifndef USB_UTM_CTRL_RWAKE_EN
  logic unused_rwake;
  assign unused_rwake = rwake_req | tmr_hit;
`endif

  always_comb begin
    next_state = state;
    if (!dev_en) begin
      next_state = ACTIVE;
    end else begin
      case (state)
        ACTIVE: begin
          if (se0_hit)       next_state = BUS_RESET;
          else if (idle_hit) next_state = SUSPEND;
        end
        BUS_RESET: begin
          if (line_state != LS_SE0) next_state = ACTIVE;
        end
        SUSPEND: begin
          if (se0_hit)    next_state = BUS_RESET;
          else if (k_hit) next_state = RESUME;
`ifdef USB_UTM_CTRL_RWAKE_EN
          else if (tmr_hit && rwake_req && line_state == LS_J) next_state = RWAKE;
`endif
        end
        RESUME: begin
          if (line_state == LS_J) next_state = ACTIVE;
          else if (se0_hit)       next_state = BUS_RESET;
        end
        RWAKE: begin
`ifdef USB_UTM_CTRL_RWAKE_EN
          if (tmr_hit) next_state = RESUME;
`else
          next_state = ACTIVE;
`endif
        end
        default: next_state = ACTIVE;
      endcase
    end
  end

  always_comb begin
    nx_suspend_m    = 1'b1;
    nx_op_mode      = OPM_NODRIVE;
    nx_usb_reset    = 1'b0;
    nx_suspended    = 1'b0;
    nx_resume_pulse = 1'b0;
    nx_wk_tx_valid  = 1'b0;
    if (dev_en) begin
      nx_suspend_m    = (next_state != SUSPEND);
      nx_op_mode      = (next_state == RWAKE) ? OPM_NOSTUFF : OPM_NORMAL;
      nx_usb_reset    = (next_state == BUS_RESET);
      nx_suspended    = (next_state == SUSPEND);
      nx_resume_pulse = (state == RESUME && next_state == ACTIVE) ||
                        (state == RWAKE && next_state == RESUME);
`ifdef USB_UTM_CTRL_RWAKE_EN
      nx_wk_tx_valid  = (next_state == RWAKE);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ACTIVE;
      cls_q        <= COND_NONE;
      suspend_m    <= 1'b1;
      op_mode      <= OPM_NODRIVE;
      usb_reset    <= 1'b0;
      suspended    <= 1'b0;
      resume_pulse <= 1'b0;
      wk_tx_valid  <= 1'b0;
    end else begin
      state        <= next_state;
      cls_q        <= (state_chg || !dev_en) ? COND_NONE : cond_cls;
      suspend_m    <= nx_suspend_m;
      op_mode      <= nx_op_mode;
      usb_reset    <= nx_usb_reset;
      suspended    <= nx_suspended;
      resume_pulse <= nx_resume_pulse;
      wk_tx_valid  <= nx_wk_tx_valid;
    end
  end

  assign wk_data = 8'h00;

endmodule

// File: tb/tb_usb_utm_ctrl.sv
// tb/tb_usb_utm_ctrl.sv - directed and random bench for usb_utm_ctrl against a run-length reference model.
module tb_usb_utm_ctrl;

  localparam int RST_CYC      = 4;
  localparam int SUSP_CYC     = 16;
  localparam int RES_CYC      = 4;
  localparam int RWK_WAIT_CYC = 20;
  localparam int RWK_DRV_CYC  = 8;

  localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11;
  localparam int M_ACT = 0, M_BR = 1, M_SUSP = 2, M_RES = 3, M_RWK = 4;

  logic       clk = 1'b0;
  logic       rst_n, dev_en, rx_active, tx_busy, rwake_req;
  logic [1:0] line_state;
  logic       suspend_m, usb_reset, suspended, resume_pulse, wk_tx_valid;
  logic [1:0] op_mode;
  logic [7:0] wk_data;

  int checks = 0;
  int errors = 0;
  int wk_cnt;

  int m_st, m_run, m_cls, m_tis;
  logic       e_sm, e_ur, e_sus, e_rp, e_wk;
  logic [1:0] e_op;

  always #5 clk = ~clk;

  usb_utm_ctrl #(
    .RST_CYC(RST_CYC), .SUSP_CYC(SUSP_CYC), .RES_CYC(RES_CYC),
    .RWK_WAIT_CYC(RWK_WAIT_CYC), .RWK_DRV_CYC(RWK_DRV_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dev_en(dev_en), .line_state(line_state),
    .rx_active(rx_active), .tx_busy(tx_busy), .rwake_req(rwake_req),
    .suspend_m(suspend_m), .op_mode(op_mode), .usb_reset(usb_reset),
    .suspended(suspended), .resume_pulse(resume_pulse),
    .wk_tx_valid(wk_tx_valid), .wk_data(wk_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle_outputs();
    m_st = M_ACT; m_run = 0; m_cls = 0; m_tis = 0;
    e_sm = 1'b1; e_op = 2'b01; e_ur = 1'b0; e_sus = 1'b0; e_rp = 1'b0; e_wk = 1'b0;
  endtask

  // Rules applied per sampled clock edge: run length of the current condition, time in state.
  task automatic model_step();
    int c;
    int nx;
    if (!rst_n || !dev_en) begin
      set_idle_outputs();
    end else begin
      c = 0;
      if (line_state == SE0 && (m_st == M_ACT || m_st == M_SUSP || m_st == M_RES)) c = 1;
      else if (m_st == M_ACT && line_state == J && !rx_active && !tx_busy) c = 2;
      else if (m_st == M_SUSP && line_state == K) c = 3;
      nx = m_st;
      case (m_st)
        M_ACT: begin
          if (m_cls == 1 && m_run >= RST_CYC) nx = M_BR;
          else if (m_cls == 2 && m_run >= SUSP_CYC) nx = M_SUSP;
        end
        M_BR: if (line_state != SE0) nx = M_ACT;
        M_SUSP: begin
          if (m_cls == 1 && m_run >= RST_CYC) nx = M_BR;
          else if (m_cls == 3 && m_run >= RES_CYC) nx = M_RES;
`ifdef USB_UTM_CTRL_RWAKE_EN
          else if (m_tis >= RWK_WAIT_CYC && rwake_req && line_state == J) nx = M_RWK;
`endif
        end
        M_RES: begin
          if (line_state == J) nx = M_ACT;
          else if (m_cls == 1 && m_run >= RST_CYC) nx = M_BR;
        end
        default: if (m_tis + 1 >= RWK_DRV_CYC) nx = M_RES;
      endcase
      e_rp = (m_st == M_RES && nx == M_ACT) || (m_st == M_RWK && nx == M_RES);
      if (nx != m_st) begin
        m_run = 0; m_cls = 0; m_tis = 0;
      end else begin
        m_tis++;
        if (c == 0) begin
          m_run = 0; m_cls = 0;
        end else if (c == m_cls) begin
          m_run++;
        end else begin
          m_run = 1; m_cls = c;
        end
      end
      m_st  = nx;
      e_sm  = (m_st != M_SUSP);
      e_op  = (m_st == M_RWK) ? 2'b10 : 2'b00;
      e_ur  = (m_st == M_BR);
      e_sus = (m_st == M_SUSP);
      e_wk  = (m_st == M_RWK);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("outs", {suspend_m, op_mode, usb_reset, suspended, resume_pulse, wk_tx_valid, wk_data},
                  {e_sm, e_op, e_ur, e_sus, e_rp, e_wk, 8'h00});
  endtask

  task automatic drive(input logic [1:0] ls, input logic rx, input logic rw, input int n);
    line_state = ls; rx_active = rx; tx_busy = 1'b0; rwake_req = rw;
    repeat (n) tick();
  endtask

  task automatic enter_suspend();
    drive(K, 1'b0, 1'b0, 1);
    drive(J, 1'b0, 1'b0, SUSP_CYC + 1);
    check("susp_entry", suspended, 1'b1);
  endtask

  initial begin
    int r, len;
    rst_n = 1'b0; dev_en = 1'b0; line_state = J;
    rx_active = 1'b0; tx_busy = 1'b0; rwake_req = 1'b0;
    set_idle_outputs();
    tick();
    check("rst_op_mode", op_mode, 2'b01);
    check("rst_suspend_m", suspend_m, 1'b1);
    check("rst_usb_reset", usb_reset, 1'b0);
    check("rst_wk_tx_valid", wk_tx_valid, 1'b0);

    rst_n = 1'b1;
    drive(J, 1'b0, 1'b0, 2);
    check("den0_op_mode", op_mode, 2'b01);
    dev_en = 1'b1;
    drive(J, 1'b0, 1'b0, 1);
    check("den1_op_mode", op_mode, 2'b00);

    drive(SE0, 1'b0, 1'b0, RST_CYC - 1);
    drive(J, 1'b0, 1'b0, 1);
    check("se0_short_no_reset", usb_reset, 1'b0);
    drive(SE0, 1'b0, 1'b0, RST_CYC);
    check("se0_n_samples_no_reset_yet", usb_reset, 1'b0);
    drive(SE0, 1'b0, 1'b0, 1);
    check("bus_reset_rise", usb_reset, 1'b1);
    drive(J, 1'b0, 1'b0, 1);
    check("bus_reset_fall", usb_reset, 1'b0);

    drive(J, 1'b0, 1'b0, SUSP_CYC);
    check("idle_n_samples_not_susp", suspended, 1'b0);
    drive(J, 1'b0, 1'b0, 1);
    check("suspend_entry", suspended, 1'b1);
    check("suspend_m_low", suspend_m, 1'b0);

    drive(K, 1'b0, 1'b0, RES_CYC);
    check("k_n_samples_still_susp", suspended, 1'b1);
    drive(K, 1'b0, 1'b0, 1);
    check("resume_suspend_m", suspend_m, 1'b1);
    check("resume_suspended", suspended, 1'b0);
    drive(SE0, 1'b0, 1'b0, 2);
    drive(J, 1'b0, 1'b0, 1);
    check("resume_pulse_high", resume_pulse, 1'b1);
    drive(J, 1'b0, 1'b0, 1);
    check("resume_pulse_one_cycle", resume_pulse, 1'b0);

    drive(J, 1'b0, 1'b0, 7);
    drive(J, 1'b1, 1'b0, 1);
    drive(J, 1'b0, 1'b0, 7);
    drive(J, 1'b0, 1'b0, 1);
    check("rx_active_blocks_suspend", suspended, 1'b0);

`ifdef USB_UTM_CTRL_RWAKE_EN
    enter_suspend();
    drive(J, 1'b0, 1'b0, 9);
    drive(J, 1'b0, 1'b1, 1);
    drive(J, 1'b0, 1'b0, 1);
    check("early_rwake_ignored", wk_tx_valid, 1'b0);
    line_state = J; rwake_req = 1'b1;
    for (int i = 0; i < 40 && !wk_tx_valid; i++) tick();
    check("rwake_tx_valid", wk_tx_valid, 1'b1);
    check("rwake_op_mode", op_mode, 2'b10);
    wk_cnt = 1;
    line_state = K; rwake_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wk_tx_valid) wk_cnt++;
    end
    check("rwake_drive_len", wk_cnt, RWK_DRV_CYC);
    check("rwake_to_resume", {suspend_m, suspended, op_mode}, 4'b1000);
    drive(J, 1'b0, 1'b0, 1);

    enter_suspend();
    drive(J, 1'b0, 1'b0, RWK_WAIT_CYC + 5);
    drive(SE0, 1'b0, 1'b1, RST_CYC + 1);
    check("se0_beats_rwake", usb_reset, 1'b1);
    check("se0_beats_rwake_wk", wk_tx_valid, 1'b0);
    drive(J, 1'b0, 1'b0, 1);

    enter_suspend();
    line_state = J; rwake_req = 1'b1;
    for (int i = 0; i < 40 && !wk_tx_valid; i++) tick();
    drive(J, 1'b0, 1'b1, 2);
    check("rwake_before_rst", wk_tx_valid, 1'b1);
    rst_n = 1'b0;
    drive(J, 1'b0, 1'b0, 1);
    check("rst_in_rwake_wk", wk_tx_valid, 1'b0);
    check("rst_in_rwake_op", op_mode, 2'b01);
    check("rst_in_rwake_sm", suspend_m, 1'b1);
    rst_n = 1'b1;
`else
    enter_suspend();
    drive(J, 1'b0, 1'b1, RWK_WAIT_CYC + 10);
    check("rwake_ignored_susp", suspended, 1'b1);
    check("rwake_ignored_wk", wk_tx_valid, 1'b0);
`endif

    for (int s = 0; s < 300; s++) begin
      r = $urandom % 10;
      len = $urandom_range(1, 40);
      dev_en = (($urandom % 25) != 0);
      tx_busy = (($urandom % 8) == 0);
      line_state = (r < 3) ? SE0 : (r < 7) ? J : (r < 9) ? K : SE1;
      rx_active = (($urandom % 8) == 0);
      rwake_req = $urandom % 2;
      if (($urandom % 60) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      repeat (len) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
